// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter: grants one cache (m0 = I-cache, m1 = D-cache)
// for a full cache-line transfer (address beat, then BEATS write-data or
// response beats). Simultaneous requests go to the master that did not
// complete the last transfer.
module bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    output logic                      m0_reqack,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m0_respack,

    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    output logic                      m1_reqack,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    input  logic                      m1_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;   // 0 = m0, 1 = m1
    logic             prio_q,  prio_d;    // master preferred on a tie
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic                      g_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] g_req;
    logic [BUS_TAG_WIDTH-1:0]  g_reqtag;
    logic                      g_respack;

    // Request-side view of whichever master currently holds the grant
    assign g_reqcyc  = grant_q ? m1_reqcyc  : m0_reqcyc;
    assign g_req     = grant_q ? m1_req     : m0_req;
    assign g_reqtag  = grant_q ? m1_reqtag  : m0_reqtag;
    assign g_respack = grant_q ? m1_respack : m0_respack;

    // State, grant, priority and beat counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and bus/master routing
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        m0_reqack   = 1'b0;
        m1_reqack   = 1'b0;
        m0_respcyc  = 1'b0;
        m1_respcyc  = 1'b0;
        m0_resp     = '0;
        m1_resp     = '0;
        m0_resptag  = '0;
        m1_resptag  = '0;

        unique case (state_q)
            IDLE: begin
                if (m0_reqcyc || m1_reqcyc) begin
                    grant_d = (m0_reqcyc && m1_reqcyc) ? prio_q : m1_reqcyc;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                bus_reqcyc = g_reqcyc;
                bus_req    = g_req;
                bus_reqtag = g_reqtag;
                m0_reqack  = bus_reqack & ~grant_q;
                m1_reqack  = bus_reqack &  grant_q;
                if (!g_reqcyc) begin
                    // Master withdrew before the address was taken; priority kept
                    state_d = IDLE;
                end else if (bus_reqack) begin
                    cnt_d   = '0;
                    state_d = g_reqtag[BUS_TAG_WIDTH-1] ? WDATA : RESP;
                end
            end

            WDATA: begin
                bus_reqcyc = g_reqcyc;
                bus_req    = g_req;
                bus_reqtag = g_reqtag;
                m0_reqack  = bus_reqack & ~grant_q;
                m1_reqack  = bus_reqack &  grant_q;
                if (g_reqcyc && bus_reqack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        prio_d  = ~grant_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            RESP: begin
                bus_respack = g_respack;
                if (grant_q) begin
                    m1_respcyc = bus_respcyc;
                    m1_resp    = bus_resp;
                    m1_resptag = bus_resptag;
                end else begin
                    m0_respcyc = bus_respcyc;
                    m0_resp    = bus_resp;
                    m0_resptag = bus_resptag;
                end
                if (bus_respcyc && g_respack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        prio_d  = ~grant_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: acts as both cache masters and the shared bus slave,
// predicting the winner of each arbitration from a simple fairness model.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned TW = 13;
    localparam int unsigned NB = 8;
    localparam int unsigned OW = 3*DW + 3*TW + 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_reqcyc, m1_reqcyc;
    logic [DW-1:0] m0_req, m1_req;
    logic [TW-1:0] m0_reqtag, m1_reqtag;
    logic          m0_reqack, m1_reqack;
    logic          m0_respcyc, m1_respcyc;
    logic [DW-1:0] m0_resp, m1_resp;
    logic [TW-1:0] m0_resptag, m1_resptag;
    logic          m0_respack, m1_respack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int total = 0;
    int bad   = 0;
    // Reference model: which master wins a simultaneous request
    int mdl_prio = 0;
    logic [DW-1:0] beat_data [NB];

    bus_arbiter #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .BEATS         (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_reqcyc  (m0_reqcyc),
        .m0_req     (m0_req),
        .m0_reqtag  (m0_reqtag),
        .m0_reqack  (m0_reqack),
        .m0_respcyc (m0_respcyc),
        .m0_resp    (m0_resp),
        .m0_resptag (m0_resptag),
        .m0_respack (m0_respack),
        .m1_reqcyc  (m1_reqcyc),
        .m1_req     (m1_req),
        .m1_reqtag  (m1_reqtag),
        .m1_reqack  (m1_reqack),
        .m1_respcyc (m1_respcyc),
        .m1_resp    (m1_resp),
        .m1_resptag (m1_resptag),
        .m1_respack (m1_respack),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] outs_vec();
        return {bus_reqcyc, bus_req, bus_reqtag, bus_respack, m0_reqack, m1_reqack,
                m0_respcyc, m1_respcyc, m0_resp, m1_resp, m0_resptag, m1_resptag};
    endfunction

    function automatic logic get_reqack(input int m);
        return (m == 1) ? m1_reqack : m0_reqack;
    endfunction

    function automatic logic get_respcyc(input int m);
        return (m == 1) ? m1_respcyc : m0_respcyc;
    endfunction

    function automatic logic [DW-1:0] get_resp(input int m);
        return (m == 1) ? m1_resp : m0_resp;
    endfunction

    function automatic logic [TW-1:0] get_resptag(input int m);
        return (m == 1) ? m1_resptag : m0_resptag;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_req(input int m, input logic cyc, input logic [DW-1:0] d, input logic [TW-1:0] t);
        if (m == 1) begin
            m1_reqcyc = cyc; m1_req = d; m1_reqtag = t;
        end else begin
            m0_reqcyc = cyc; m0_req = d; m0_reqtag = t;
        end
    endtask

    task automatic set_respack(input int m, input logic a);
        if (m == 1) m1_respack = a;
        else        m0_respack = a;
    endtask

    task automatic clear_inputs();
        reset = 1'b0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        m0_respack  = 1'b0;
        m1_respack  = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        mdl_prio = 0;
    endtask

    task automatic fill_pattern(input int base);
        for (int i = 0; i < NB; i++) beat_data[i] = DW'(base + i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) beat_data[i] = {$urandom, $urandom};
    endtask

    // Entry: settled in an IDLE cycle with master m's request visible.
    // Exit: settled in the IDLE cycle after the transfer (or after reset).
    task automatic serve_txn(input int m, input logic [TW-1:0] tag, input logic [DW-1:0] addr, input int rst_at);
        int   other;
        int   i;
        int   guard;
        int   waits;
        logic v, a, ack;
        other = 1 - m;

        total++;
        if (bus_reqcyc !== 1'b0) begin
            bad++; $display("FAIL grant_latency m=%0d bus_reqcyc got=%b exp=0", m, bus_reqcyc);
        end

        tick();
        waits = $urandom_range(0, 2);
        for (int k = 0; k <= waits; k++) begin
            bus_reqack = (k == waits);
            settle();
            total++;
            if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, addr, tag}) begin
                bad++; $display("FAIL addr_mirror m=%0d got=%b/%h/%h exp=1/%h/%h", m, bus_reqcyc, bus_req, bus_reqtag, addr, tag);
            end
            total++;
            if ({get_reqack(m), get_reqack(other)} !== {bus_reqack, 1'b0}) begin
                bad++; $display("FAIL addr_reqack m=%0d got=%b%b exp=%b0", m, get_reqack(m), get_reqack(other), bus_reqack);
            end
            tick();
        end
        bus_reqack = 1'b0;

        i = 0;
        guard = 0;
        if (tag[TW-1]) begin
            while (i < NB && guard < 100) begin
                ack = ($urandom_range(0, 2) != 0);
                set_req(m, 1'b1, beat_data[i], tag);
                bus_reqack  = ack;
                bus_respcyc = 1'($urandom_range(0, 1));
                set_respack(m, 1'b1);
                settle();
                total++;
                if ({bus_reqcyc, bus_req} !== {1'b1, beat_data[i]}) begin
                    bad++; $display("FAIL wdata_mirror beat=%0d got=%b/%h exp=1/%h", i, bus_reqcyc, bus_req, beat_data[i]);
                end
                total++;
                if ({get_reqack(m), get_reqack(other)} !== {ack, 1'b0}) begin
                    bad++; $display("FAIL wdata_reqack beat=%0d got=%b%b exp=%b0", i, get_reqack(m), get_reqack(other), ack);
                end
                total++;
                if ({bus_respack, m0_respcyc, m1_respcyc} !== 3'b000) begin
                    bad++; $display("FAIL wdata_no_resp got=%b%b%b exp=000", bus_respack, m0_respcyc, m1_respcyc);
                end
                if (ack) i++;
                guard++;
                tick();
            end
            set_respack(m, 1'b0);
        end else begin
            set_req(m, 1'b0, '0, '0);
            while (i < NB && guard < 100) begin
                v = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 3) != 0);
                bus_respcyc = v;
                bus_resp    = beat_data[i];
                bus_resptag = tag;
                set_respack(m, a);
                set_respack(other, 1'b1);
                if (rst_at >= 0 && i == rst_at) begin
                    reset = 1'b1;
                    settle();
                    total++;
                    if (outs_vec() !== '0) begin
                        bad++; $display("FAIL reset_midxfer outputs got=%h exp=0", outs_vec());
                    end
                    tick();
                    reset = 1'b0;
                    settle();
                    total++;
                    if (outs_vec() !== '0) begin
                        bad++; $display("FAIL reset_release outputs got=%h exp=0", outs_vec());
                    end
                    clear_inputs();
                    mdl_prio = 0;
                    return;
                end
                settle();
                total++;
                if ({get_respcyc(m), get_respcyc(other)} !== {v, 1'b0}) begin
                    bad++; $display("FAIL resp_cyc beat=%0d got=%b%b exp=%b0", i, get_respcyc(m), get_respcyc(other), v);
                end
                if (v) begin
                    total++;
                    if ({get_resp(m), get_resptag(m)} !== {beat_data[i], tag}) begin
                        bad++; $display("FAIL resp_data beat=%0d got=%h/%h exp=%h/%h", i, get_resp(m), get_resptag(m), beat_data[i], tag);
                    end
                end
                total++;
                if ({bus_respack, bus_reqcyc} !== {a, 1'b0}) begin
                    bad++; $display("FAIL resp_ack beat=%0d got=%b%b exp=%b0", i, bus_respack, bus_reqcyc, a);
                end
                if (v && a) i++;
                guard++;
                tick();
            end
            set_respack(other, 1'b0);
        end

        total++;
        if (i != NB) begin
            bad++; $display("FAIL txn_timeout m=%0d beats got=%0d exp=%0d", m, i, NB);
        end

        // Transfer must be over: stray bus activity is now ignored
        set_req(m, 1'b0, '0, '0);
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        set_respack(m, 1'b1);
        settle();
        total++;
        if ({bus_reqcyc, bus_respack, m0_respcyc, m1_respcyc, m0_reqack, m1_reqack} !== 6'b0) begin
            bad++; $display("FAIL idle_after m=%0d got=%b%b%b%b%b%b exp=000000", m,
                            bus_reqcyc, bus_respack, m0_respcyc, m1_respcyc, m0_reqack, m1_reqack);
        end
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        set_respack(m, 1'b0);
        mdl_prio = other;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        set_req(0, 1'b1, {$urandom, $urandom}, 13'h0001);
        set_req(1, 1'b1, {$urandom, $urandom}, 13'h1002);
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        m0_respack  = 1'b1;
        m1_respack  = 1'b1;
        #3;
        total++;
        if (outs_vec() !== '0) begin
            bad++; $display("FAIL reset_assert outputs got=%h exp=0", outs_vec());
        end
        tick(); settle();
        total++;
        if (outs_vec() !== '0) begin
            bad++; $display("FAIL reset_hold outputs got=%h exp=0", outs_vec());
        end
        clear_inputs();
        tick(); settle();
        total++;
        if (outs_vec() !== '0) begin
            bad++; $display("FAIL reset_release_idle outputs got=%h exp=0", outs_vec());
        end
        mdl_prio = 0;
    endtask

    task automatic test_read_m0();
        logic [DW-1:0] addr;
        addr = {$urandom, $urandom};
        tick();
        fill_pattern(32'h10);
        set_req(0, 1'b1, addr, 13'h0001);
        settle();
        serve_txn(0, 13'h0001, addr, -1);
    endtask

    task automatic test_write_m1();
        logic [DW-1:0] addr;
        addr = {$urandom, $urandom};
        tick();
        fill_pattern(32'hA0);
        set_req(1, 1'b1, addr, 13'h1005);
        settle();
        serve_txn(1, 13'h1005, addr, -1);
    endtask

    task automatic run_pair(input logic [TW-1:0] t0, input logic [TW-1:0] t1);
        logic [DW-1:0] addr [2];
        logic [TW-1:0] tg   [2];
        int w;
        addr[0] = {$urandom, $urandom};
        addr[1] = {$urandom, $urandom};
        tg[0] = t0;
        tg[1] = t1;
        set_req(0, 1'b1, addr[0], tg[0]);
        set_req(1, 1'b1, addr[1], tg[1]);
        settle();
        w = mdl_prio;
        fill_random();
        serve_txn(w, tg[w], addr[w], -1);
        fill_random();
        serve_txn(1 - w, tg[1 - w], addr[1 - w], -1);
    endtask

    task automatic test_arbitration();
        apply_reset();
        run_pair(13'h0002, 13'h0003);
        test_read_m0();
        tick();
        run_pair(13'h1004, 13'h0006);
    endtask

    task automatic test_reset_midxfer();
        logic [DW-1:0] addr;
        tick();
        fill_random();
        addr = {$urandom, $urandom};
        set_req(0, 1'b1, addr, 13'h0042);
        settle();
        serve_txn(0, 13'h0042, addr, 4);
        tick();
        fill_random();
        addr = {$urandom, $urandom};
        set_req(1, 1'b1, addr, 13'h0043);
        settle();
        serve_txn(1, 13'h0043, addr, -1);
    endtask

    task automatic test_spurious_abort();
        logic [DW-1:0] addr;
        apply_reset();
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        m0_respack  = 1'b1;
        m1_respack  = 1'b1;
        settle();
        total++;
        if ({bus_respack, m0_respcyc, m1_respcyc} !== 3'b000) begin
            bad++; $display("FAIL spurious_resp got=%b%b%b exp=000", bus_respack, m0_respcyc, m1_respcyc);
        end
        clear_inputs();
        // m0 completes, so m1 is now preferred on a tie
        test_read_m0();
        tick();
        addr = {$urandom, $urandom};
        set_req(1, 1'b1, addr, 13'h0077);
        settle();
        tick(); settle();
        total++;
        if ({bus_reqcyc, bus_req} !== {1'b1, addr}) begin
            bad++; $display("FAIL abort_addr got=%b/%h exp=1/%h", bus_reqcyc, bus_req, addr);
        end
        tick();
        set_req(1, 1'b0, '0, '0);
        settle();
        total++;
        if ({bus_reqcyc, m1_reqack, m0_reqack} !== 3'b000) begin
            bad++; $display("FAIL abort_drop got=%b%b%b exp=000", bus_reqcyc, m1_reqack, m0_reqack);
        end
        tick();
        run_pair(13'h0008, 13'h0009);
    endtask

    task automatic test_random();
        logic [DW-1:0] addr;
        logic [TW-1:0] tag;
        int m;
        for (int n = 0; n < 6; n++) begin
            tick();
            if ($urandom_range(0, 1) == 1) begin
                run_pair({1'($urandom_range(0, 1)), 12'($urandom)}, {1'($urandom_range(0, 1)), 12'($urandom)});
            end else begin
                m    = int'($urandom_range(0, 1));
                addr = {$urandom, $urandom};
                tag  = {1'($urandom_range(0, 1)), 12'($urandom)};
                fill_random();
                set_req(m, 1'b1, addr, tag);
                settle();
                serve_txn(m, tag, addr, -1);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read_m0();
        test_write_m1();
        test_arbitration();
        test_reset_midxfer();
        test_spurious_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
